bitty_exec_ctrl: RTL

Fetch/execute sequencer for the bitty core, the PC register and the instruction memory. It decides when the PC advances, when the core is started on a fetched instruction, and when execution stops. Supports run, halt, single-step, a hardware breakpoint and an execution watchdog. It sits between the memory/PC pair and the core, and drives their enables.

---
 rtl/bitty_exec_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bitty_exec_ctrl.sv
// ----------------------------------------------------------------------------
// bitty_exec_ctrl
//
// Fetch/execute sequencer for the bitty core. Sits between the PC register /
// instruction memory pair and the core: waits for the memory read of the
// current PC, issues the instruction to the core, waits for the core to
// finish, then advances the PC. Supports run, halt, single-step, one hardware
// breakpoint and an execution watchdog that parks the sequencer in FAULT.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high
//   start        in   pulse: begin from IDLE, resume from HALT
//   halt_req     in   pulse: stop at the next instruction boundary
//   step         in   pulse: in HALT, execute exactly one instruction
//   bp_en        in   breakpoint enable
//   bp_addr      in   breakpoint PC
//   pc_addr      in   current PC from the PC register
//   instr_in     in   instruction memory read data
//   core_done    in   core finished the current instruction
//   run_core     out  one-cycle start pulse to the core
//   pc_en        out  one-cycle PC increment enable
//   ir           out  instruction issued to the core
//   busy         out  high in FETCH/ISSUE/EXEC/COMMIT
//   halted       out  high in HALT
//   fault        out  high in FAULT (watchdog expired)
//   instr_count  out  committed instructions, saturating at 0xFFFF
// ----------------------------------------------------------------------------
module bitty_exec_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int MEM_LAT = 1,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt_req,
    input  logic               step,
    input  logic               bp_en,
    input  logic [ADDR_W-1:0]  bp_addr,
    input  logic [ADDR_W-1:0]  pc_addr,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               core_done,
    output logic               run_core,
    output logic               pc_en,
    output logic [INSTR_W-1:0] ir,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [15:0]        instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    // lat_cnt counts 0..MEM_LAT-1 inside FETCH; wd_cnt counts 0..TIMEOUT-1
    // inside EXEC.
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [LAT_W-1:0] lat_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             halt_pend;
    logic             step_mode;
    logic             bp_skip;
    logic             bp_hit;

    assign busy   = (state == S_FETCH) || (state == S_ISSUE) ||
                    (state == S_EXEC)  || (state == S_COMMIT);
    assign halted = (state == S_HALT);
    assign fault  = (state == S_FAULT);

    // The PC is only stable for comparison on the first FETCH cycle. bp_skip
    // suppresses the hit on the instruction we are resuming from, otherwise
    // a resume at the breakpoint address would re-break immediately.
    assign bp_hit = (lat_cnt == '0) && bp_en && (pc_addr == bp_addr) && !bp_skip;

    always_comb begin
        // NOTE: every path assigns state_next through this default, so the
        // block cannot infer a latch when a case arm leaves it untouched.
        state_next = state;
        unique case (state)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH: begin
                if (bp_hit)                   state_next = S_HALT;
                else if (lat_cnt == LAT_LAST) state_next = S_ISSUE;
            end
            S_ISSUE:  state_next = S_EXEC;
            S_EXEC: begin
                // core_done on the last watchdog cycle still commits.
                if (core_done)              state_next = S_COMMIT;
                else if (wd_cnt == WD_LAST) state_next = S_FAULT;
            end
            S_COMMIT: state_next = (halt_pend || step_mode) ? S_HALT : S_FETCH;
            S_HALT:   if (start || step) state_next = S_FETCH;
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            run_core    <= 1'b0;
            pc_en       <= 1'b0;
            ir          <= '0;
            instr_count <= '0;
            lat_cnt     <= '0;
            wd_cnt      <= '0;
            halt_pend   <= 1'b0;
            step_mode   <= 1'b0;
            bp_skip     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values of the others, regardless of statement order.
            state <= state_next;

            // Registered pulses are aligned with the ISSUE and COMMIT cycles
            // by decoding the state being entered.
            run_core <= (state_next == S_ISSUE);
            pc_en    <= (state_next == S_COMMIT);

            lat_cnt <= (state == S_FETCH && state_next == S_FETCH) ? lat_cnt + 1'b1 : '0;
            wd_cnt  <= (state == S_EXEC  && state_next == S_EXEC)  ? wd_cnt + 1'b1  : '0;

            if (state == S_ISSUE) ir <= instr_in;

            if (state == S_IDLE && start)
                instr_count <= '0;
            else if (state == S_COMMIT && instr_count != 16'hFFFF)
                instr_count <= instr_count + 16'd1;

            // Any entry into HALT consumes a pending stop request, including a
            // breakpoint stop, so a later resume is not cut short by it.
            if (state_next == S_HALT)
                halt_pend <= 1'b0;
            else if (busy && halt_req)
                halt_pend <= 1'b1;

            // start beats step when both arrive in the same HALT cycle.
            if (state == S_HALT && (start || step))
                step_mode <= !start;
            else if (state_next == S_HALT)
                step_mode <= 1'b0;

            if (state == S_HALT && state_next == S_FETCH)
                bp_skip <= 1'b1;
            else if (state == S_FETCH && state_next != S_FETCH)
                bp_skip <= 1'b0;
        end
    end

endmodule
